// File: rtl/uc_menu_parametrizado_if.sv
// Signal bundle between the menu control unit and its surroundings: button register, transmitter, base game.
// The slave side is the control unit; the master side drives buttons, acknowledges and pronto.
interface uc_menu_parametrizado_if #(
    parameter int LARGURA_TELA = 8,
    parameter int LARG_CURSOR  = 2
);
    logic                    ocorreu_jogada;
    logic                    tiro;
    logic                    especial;
    logic                    fim_envia_dados;
    logic                    pronto;
    logic                    reset_reg_jogada;
    logic                    enable_reg_jogada;
    logic                    envia_dados;
    logic                    iniciar;
    logic                    jogo_base_em_andamento;
    logic                    reset_jogo_base;
    logic [LARGURA_TELA-1:0] tela_renderizada;
    logic [LARG_CURSOR-1:0]  cursor;
    logic                    erro_envio;
    logic [3:0]              db_estado;

    modport master (
        output ocorreu_jogada, tiro, especial, fim_envia_dados, pronto,
        input  reset_reg_jogada, enable_reg_jogada, envia_dados, iniciar,
               jogo_base_em_andamento, reset_jogo_base, tela_renderizada,
               cursor, erro_envio, db_estado
    );

    modport slave (
        input  ocorreu_jogada, tiro, especial, fim_envia_dados, pronto,
        output reset_reg_jogada, enable_reg_jogada, envia_dados, iniciar,
               jogo_base_em_andamento, reset_jogo_base, tela_renderizada,
               cursor, erro_envio, db_estado
    );
endinterface

// File: rtl/uc_menu_parametrizado.sv
// N-entry cursor menu with one shared send/acknowledge sequencer; registered Moore outputs, press-to-send in 3 cycles.
// Waits on fim_envia_dados with no backpressure on inputs; UC_MENU_TIMEOUT_EN adds ack timeout, retries and erro_envio.
module uc_menu_parametrizado #(
    parameter int NUM_ITENS      = 3,
    parameter int LARGURA_TELA   = 8,
    parameter int TELA_BASE      = 'hF0,
    parameter int TIMEOUT_CICLOS = 1000,
    parameter int MAX_TENTATIVAS = 3
) (
    input logic                   clock,
    input logic                   reset,
    uc_menu_parametrizado_if.slave bus
);
    localparam int LARG_CURSOR = $clog2(NUM_ITENS);

    localparam logic [LARGURA_TELA-1:0] TELA_MENU      = LARGURA_TELA'(TELA_BASE);
    localparam logic [LARGURA_TELA-1:0] TELA_JOGO      = LARGURA_TELA'(TELA_BASE + NUM_ITENS);
    localparam logic [LARGURA_TELA-1:0] TELA_GAME_OVER = LARGURA_TELA'(TELA_BASE + NUM_ITENS + 1);
    localparam logic [LARGURA_TELA-1:0] TELA_REG_PONT  = LARGURA_TELA'(TELA_BASE + NUM_ITENS + 2);
    localparam logic [LARG_CURSOR-1:0]  CURSOR_ULTIMO  = LARG_CURSOR'(NUM_ITENS - 1);

    if (NUM_ITENS < 2 || TIMEOUT_CICLOS < 1 || MAX_TENTATIVAS < 1 ||
        TELA_BASE + 2 * NUM_ITENS + 2 >= 2 ** LARGURA_TELA) begin : g_param_invalidos
        $error("uc_menu_parametrizado: invalid parameter combination");
    end

    typedef enum logic [3:0] {
        INICIAL      = 4'd0,
        MENU         = 4'd1,
        REGISTRA     = 4'd2,
        DECIDE       = 4'd3,
        ENVIA        = 4'd4,
        ESPERA_ENVIA = 4'd5,
        REINICIA     = 4'd6,
        INICIAR      = 4'd7,
        ESPERA_JOGO  = 4'd8,
        GAME_OVER    = 4'd9,
        SUBTELA      = 4'd10,
        REG_PONT     = 4'd11,
        ERRO         = 4'd15
    } estado_t;

    estado_t                 estado_q, estado_d;
    estado_t                 contexto_q, contexto_d;
    estado_t                 destino_q, destino_d;
    logic [LARGURA_TELA-1:0] tela_q, tela_d;
    logic [LARG_CURSOR-1:0]  cursor_q, cursor_d;
    logic [LARG_CURSOR-1:0]  cursor_prox;

    logic reset_reg_q, enable_reg_q, envia_q, iniciar_q, andamento_q, reset_jogo_q;

`ifdef UC_MENU_TIMEOUT_EN
    localparam int LARG_CNT  = $clog2(TIMEOUT_CICLOS + 1);
    localparam int LARG_TENT = $clog2(MAX_TENTATIVAS + 1);

    logic [LARG_CNT-1:0]  cnt_q, cnt_d;
    logic [LARG_TENT-1:0] tent_q, tent_d;
    logic                 erro_q;
`endif

    assign cursor_prox = (cursor_q == CURSOR_ULTIMO) ? '0 : cursor_q + LARG_CURSOR'(1);

    always_comb begin
        estado_d   = estado_q;
        contexto_d = contexto_q;
        destino_d  = destino_q;
        tela_d     = tela_q;
        cursor_d   = cursor_q;
`ifdef UC_MENU_TIMEOUT_EN
        cnt_d      = cnt_q;
        tent_d     = tent_q;
`endif
        case (estado_q)
            INICIAL: begin
                cursor_d = '0;
                estado_d = MENU;
            end
            MENU, SUBTELA, GAME_OVER, REG_PONT: begin
                if (bus.ocorreu_jogada) estado_d = REGISTRA;
            end
            REGISTRA: estado_d = DECIDE;
            DECIDE: begin
                // Default is a silent return; every branch that sends overrides it with ENVIA.
                estado_d = contexto_q;
                case (contexto_q)
                    MENU: begin
                        if (bus.tiro) begin
                            estado_d = ENVIA;
                            if (cursor_q == '0) begin
                                tela_d    = TELA_JOGO;
                                destino_d = REINICIA;
                            end else begin
                                tela_d    = TELA_REG_PONT + LARGURA_TELA'(cursor_q);
                                destino_d = SUBTELA;
                            end
                        end else if (bus.especial) begin
                            estado_d  = ENVIA;
                            cursor_d  = cursor_prox;
                            tela_d    = TELA_MENU + LARGURA_TELA'(cursor_prox);
                            destino_d = MENU;
                        end
                    end
                    SUBTELA: begin
                        if (!bus.tiro && bus.especial) begin
                            estado_d  = ENVIA;
                            tela_d    = TELA_MENU + LARGURA_TELA'(cursor_q);
                            destino_d = MENU;
                        end
                    end
                    GAME_OVER: begin
                        if (bus.tiro) begin
                            estado_d  = ENVIA;
                            tela_d    = TELA_REG_PONT;
                            destino_d = REG_PONT;
                        end else if (bus.especial) begin
                            estado_d  = ENVIA;
                            cursor_d  = '0;
                            tela_d    = TELA_MENU;
                            destino_d = MENU;
                        end
                    end
                    REG_PONT: begin
                        if (bus.tiro) begin
                            estado_d  = ENVIA;
                            cursor_d  = '0;
                            tela_d    = TELA_MENU;
                            destino_d = MENU;
                        end
                    end
                    default: estado_d = ERRO;
                endcase
            end
            ENVIA: begin
                estado_d = ESPERA_ENVIA;
`ifdef UC_MENU_TIMEOUT_EN
                cnt_d    = '0;
`endif
            end
            ESPERA_ENVIA: begin
                if (bus.fim_envia_dados) begin
                    estado_d = destino_q;
`ifdef UC_MENU_TIMEOUT_EN
                    tent_d   = '0;
                end else if (cnt_q == LARG_CNT'(TIMEOUT_CICLOS - 1)) begin
                    if (int'(tent_q) + 1 >= MAX_TENTATIVAS) begin
                        estado_d = ERRO;
                    end else begin
                        tent_d   = tent_q + LARG_TENT'(1);
                        estado_d = ENVIA;
                    end
                end else begin
                    cnt_d = cnt_q + LARG_CNT'(1);
`endif
                end
            end
            REINICIA: estado_d = INICIAR;
            INICIAR:  estado_d = ESPERA_JOGO;
            ESPERA_JOGO: begin
                if (bus.pronto) begin
                    tela_d    = TELA_GAME_OVER;
                    destino_d = GAME_OVER;
                    estado_d  = ENVIA;
                end
            end
            ERRO:    estado_d = ERRO;
            default: estado_d = ERRO;
        endcase

        if (estado_d inside {MENU, SUBTELA, GAME_OVER, REG_PONT}) contexto_d = estado_d;
    end

    // Outputs are registered from the next state so they stay Moore and glitch-free.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q     <= INICIAL;
            contexto_q   <= MENU;
            destino_q    <= MENU;
            tela_q       <= TELA_MENU;
            cursor_q     <= '0;
            reset_reg_q  <= 1'b1;
            enable_reg_q <= 1'b0;
            envia_q      <= 1'b0;
            iniciar_q    <= 1'b0;
            andamento_q  <= 1'b0;
            reset_jogo_q <= 1'b0;
`ifdef UC_MENU_TIMEOUT_EN
            cnt_q        <= '0;
            tent_q       <= '0;
            erro_q       <= 1'b0;
`endif
        end else begin
            estado_q     <= estado_d;
            contexto_q   <= contexto_d;
            destino_q    <= destino_d;
            tela_q       <= tela_d;
            cursor_q     <= cursor_d;
            reset_reg_q  <= (estado_d == INICIAL);
            enable_reg_q <= (estado_d == REGISTRA);
            envia_q      <= (estado_d == ENVIA);
            iniciar_q    <= (estado_d == INICIAR);
            andamento_q  <= (estado_d == INICIAR) || (estado_d == ESPERA_JOGO);
            reset_jogo_q <= (estado_d == REINICIA);
`ifdef UC_MENU_TIMEOUT_EN
            cnt_q        <= cnt_d;
            tent_q       <= tent_d;
            erro_q       <= erro_q || (estado_d == ERRO);
`endif
        end
    end

    assign bus.reset_reg_jogada       = reset_reg_q;
    assign bus.enable_reg_jogada      = enable_reg_q;
    assign bus.envia_dados            = envia_q;
    assign bus.iniciar                = iniciar_q;
    assign bus.jogo_base_em_andamento = andamento_q;
    assign bus.reset_jogo_base        = reset_jogo_q;
    assign bus.tela_renderizada       = tela_q;
    assign bus.cursor                 = cursor_q;
    assign bus.db_estado              = estado_q;
`ifdef UC_MENU_TIMEOUT_EN
    assign bus.erro_envio             = erro_q;
`else
    assign bus.erro_envio             = 1'b0;
`endif
endmodule
